// File: rtl/wtm_pipe.sv
// wtm_pipe: pipelined Wallace-tree multiplier with valid/ready flow control.
// Partial products are reduced by full-adder (3:2) layers down to a sum and a
// carry row, registered, then merged by a carry-propagate adder.
// Ports:
//   clock, resetn          rising-edge clock, synchronous active-low reset
//   in_valid / in_ready    operand handshake (in1, in2, is_signed)
//   out_valid / out_ready  product handshake (result, cout)
//   result                 2*WIDTH-bit product, zero while out_valid is low
//   cout                   product does not fit in WIDTH bits
// Macro WTM_SIGNED_EN: enables two's-complement mode via Baugh-Wooley
// correction. Without it is_signed is ignored and every product is unsigned.
module wtm_pipe #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               cout
);

   localparam int P = 2 * WIDTH;
`ifdef WTM_SIGNED_EN
   localparam int NR = WIDTH + 1;
`else
   localparam int NR = WIDTH;
`endif

   // Row count after l layers of 3:2 compression.
   function automatic int rows_at(input int n, input int l);
      int c;
      c = n;
      for (int k = 0; k < l; k++) c = c - c / 3;
      return c;
   endfunction

   function automatic int n_levels(input int n);
      int c;
      int l;
      c = n;
      l = 0;
      for (int k = 0; k < 32; k++) begin
         if (c > 2) begin
            c = c - c / 3;
            l = l + 1;
         end
      end
      return l;
   endfunction

   localparam int LV = n_levels(NR);

   logic adv;

   // Every stage moves together; the pipe stalls only when the
   // product at the output is valid and not being taken.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv | ~resetn;

   logic [P-1:0] pp [NR];

   for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      logic [WIDTH-1:0] m;
`ifdef WTM_SIGNED_EN
      // Baugh-Wooley: invert the cross terms that pair one sign bit
      // with one magnitude bit.
      localparam logic [WIDTH-1:0] INV = (i == WIDTH - 1) ?
         {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      assign m = (in1 & {WIDTH{in2[i]}}) ^ (INV & {WIDTH{is_signed}});
`else
      assign m = in1 & {WIDTH{in2[i]}};
`endif
      assign pp[i] = {{WIDTH{1'b0}}, m} << i;
   end

`ifdef WTM_SIGNED_EN
   // Constant ones at bit WIDTH and the top bit complete the correction.
   localparam logic [P-1:0] BW_K = (P'(1) << WIDTH) | (P'(1) << (P - 1));
   assign pp[WIDTH] = is_signed ? BW_K : '0;
`endif

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int C = rows_at(NR, l);
      localparam int G = C / 3;
      logic [P-1:0] cur [C];
      logic [P-1:0] nx  [C - G];

      for (genvar k = 0; k < C; k++) begin : g_cur
         if (l == 0) begin : g_top
            assign cur[k] = pp[k];
         end else begin : g_prv
            assign cur[k] = g_lvl[l-1].nx[k];
         end
      end

      for (genvar g = 0; g < G; g++) begin : g_csa
         logic [P-1:0] x;
         logic [P-1:0] y;
         logic [P-1:0] z;
         assign x = cur[3*g];
         assign y = cur[3*g+1];
         assign z = cur[3*g+2];
         assign nx[2*g]   = x ^ y ^ z;
         assign nx[2*g+1] = {(x[P-2:0] & y[P-2:0]) |
                             (x[P-2:0] & z[P-2:0]) |
                             (y[P-2:0] & z[P-2:0]), 1'b0};
      end

      for (genvar k = 0; k < C - 3*G; k++) begin : g_pass
         assign nx[2*G + k] = cur[3*G + k];
      end
   end

   logic [P-1:0] t_sum;
   logic [P-1:0] t_car;

   if (LV == 0) begin : g_fin0
      assign t_sum = pp[0];
      assign t_car = pp[1];
   end else begin : g_fin
      assign t_sum = g_lvl[LV-1].nx[0];
      assign t_car = g_lvl[LV-1].nx[1];
   end

   // Carry row lives only in the first stage; the adder sits behind it.
   logic [P-1:0] cry;

   always_ff @(posedge clock) begin
      if (resetn && adv) cry <= t_car;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic         v;
      logic [P-1:0] d;
      logic         s;
      logic         nv;
      logic [P-1:0] nd;
      logic         ns;

      if (k == 0) begin : g_head
         assign nv = in_valid;
         assign nd = t_sum;
         assign ns = is_signed;
      end else if (k == 1) begin : g_cpa
         assign nv = g_st[0].v;
         assign nd = g_st[0].d + cry;
         assign ns = g_st[0].s;
      end else begin : g_dly
         assign nv = g_st[k-1].v;
         assign nd = g_st[k-1].d;
         assign ns = g_st[k-1].s;
      end

      always_ff @(posedge clock) begin
         if (!resetn) begin
            v <= 1'b0;
         end else if (adv) begin
            v <= nv;
            d <= nd;
            s <= ns;
         end
      end
   end

   logic [P-1:0] prod;
   logic         ovf;

   if (STAGES == 1) begin : g_out1
      assign prod = g_st[0].d + cry;
   end else begin : g_outn
      assign prod = g_st[STAGES-1].d;
   end

   assign out_valid = g_st[STAGES-1].v;

`ifdef WTM_SIGNED_EN
   logic [WIDTH:0] hi;
   assign hi  = prod[P-1:WIDTH-1];
   assign ovf = g_st[STAGES-1].s ? ~((&hi) | ~(|hi))
                                 : |prod[P-1:WIDTH];
`else
   logic unused_sgn;
   assign unused_sgn = g_st[STAGES-1].s;
   assign ovf        = |prod[P-1:WIDTH];
`endif

   assign result = out_valid ? prod : '0;
   assign cout   = out_valid & ovf;

endmodule

// File: tb/tb_wtm_pipe.sv
// tb_wtm_pipe: directed and reference-model checks of wtm_pipe
// (WIDTH=5/STAGES=2 instance plus a WIDTH=8/STAGES=4 instance).
module tb_wtm_pipe;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       resetn;
   logic       in_valid, in_ready, is_signed;
   logic       out_valid, out_ready, cout;
   logic [4:0] in1, in2;
   logic [9:0] result;

   logic        b_in_valid, b_in_ready, b_is_signed;
   logic        b_out_valid, b_out_ready, b_cout;
   logic [7:0]  b_in1, b_in2;
   logic [15:0] b_result;

   int errors = 0;
   int checks = 0;

   wtm_pipe #(.WIDTH(5), .STAGES(2)) u_dut (
      .clock(clock), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .is_signed(is_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout)
   );

   wtm_pipe #(.WIDTH(8), .STAGES(4)) u_big (
      .clock(clock), .resetn(resetn),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in1(b_in1), .in2(b_in2), .is_signed(b_is_signed),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .result(b_result), .cout(b_cout)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [16:0] ref8(logic [7:0] a, logic [7:0] b,
                                        logic s);
      int          pa, pb;
      logic [15:0] p;
      logic        c;
      logic        sm;
`ifdef WTM_SIGNED_EN
      sm = s;
`else
      sm = s & 1'b0;
`endif
      if (sm) begin
         pa = {{24{a[7]}}, a};
         pb = {{24{b[7]}}, b};
         p  = 16'(pa * pb);
         c  = !((&p[15:7]) || !(|p[15:7]));
      end else begin
         pa = {24'd0, a};
         pb = {24'd0, b};
         p  = 16'(pa * pb);
         c  = |p[15:8];
      end
      return {c, p};
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      in_valid = 1'b1; in1 = 5'd7; in2 = 5'd7; is_signed = 1'b0;
      out_ready = 1'b0;
      b_in_valid = 1'b1; b_in1 = 8'd9; b_in2 = 8'd9; b_is_signed = 1'b0;
      b_out_ready = 1'b0;
      tick(); settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready: got %b expected 1", b_in_ready); end
      tick(); settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 10'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
      resetn = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0;
      out_ready = 1'b1; b_out_ready = 1'b1;
      tick(); settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_single();
      tick();
      in1 = 5'd3; in2 = 5'd8; in_valid = 1'b1; is_signed = 1'b0;
      settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", in_ready); end
      tick(); in_valid = 1'b0; settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", out_valid); end
      tick(); settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (result !== 10'd24) begin errors++; $display("FAIL single_result: got %0d expected 24", result); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL single_cout: got %b expected 0", cout); end
      tick(); settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_bubble: got %b expected 0", out_valid); end
      checks++; if (result !== 10'd0) begin errors++; $display("FAIL single_zero: got %0d expected 0", result); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] va [3];
      logic [4:0] vb [3];
      logic [9:0] er [3];
      logic       ec [3];
      va = '{5'd31, 5'd29, 5'd20};
      vb = '{5'd3, 5'd7, 5'd0};
      er = '{10'd93, 10'd203, 10'd0};
      ec = '{1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k < 3) begin
            in1 = va[k]; in2 = vb[k]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         settle();
         if (k >= 2) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k-2, out_valid); end
            checks++; if (result !== er[k-2]) begin errors++; $display("FAIL b2b_result[%0d]: got %0d expected %0d", k-2, result, er[k-2]); end
            checks++; if (cout !== ec[k-2]) begin errors++; $display("FAIL b2b_cout[%0d]: got %b expected %b", k-2, cout, ec[k-2]); end
         end
      end
      tick(); settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_stall();
      tick();
      in1 = 5'd25; in2 = 5'd16; in_valid = 1'b1; out_ready = 1'b0;
      settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready0: got %b expected 1", in_ready); end
      tick(); in1 = 5'd7; in2 = 5'd9; settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0", out_valid); end
      for (int k = 0; k < 4; k++) begin
         tick(); in1 = 5'd2; in2 = 5'd3; settle();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, out_valid); end
         checks++; if (result !== 10'd400) begin errors++; $display("FAIL stall_result[%0d]: got %0d expected 400", k, result); end
         checks++; if (cout !== 1'b1) begin errors++; $display("FAIL stall_cout[%0d]: got %b expected 1", k, cout); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full[%0d]: got %b expected 0", k, in_ready); end
      end
      tick(); out_ready = 1'b1; settle();
      checks++; if (result !== 10'd400) begin errors++; $display("FAIL release_result: got %0d expected 400", result); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
      tick(); in_valid = 1'b0; settle();
      checks++; if (result !== 10'd63) begin errors++; $display("FAIL release_second: got %0d expected 63", result); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL release_second_cout: got %b expected 1", cout); end
      tick(); settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_third_valid: got %b expected 1", out_valid); end
      checks++; if (result !== 10'd6) begin errors++; $display("FAIL release_third: got %0d expected 6", result); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL release_third_cout: got %b expected 0", cout); end
      tick(); settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_signed();
      logic [4:0] va [4];
      logic [4:0] vb [4];
      logic       vs [4];
      logic [9:0] er [4];
      logic       ec [4];
      va = '{5'd31, 5'd31, 5'd29, 5'd24};
      vb = '{5'd31, 5'd31, 5'd5, 5'd4};
      vs = '{1'b1, 1'b0, 1'b1, 1'b1};
`ifdef WTM_SIGNED_EN
      er = '{10'd1, 10'd961, 10'd1009, 10'd992};
      ec = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      er = '{10'd961, 10'd961, 10'd145, 10'd96};
      ec = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k < 4) begin
            in1 = va[k]; in2 = vb[k]; is_signed = vs[k]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0; is_signed = 1'b0;
         end
         settle();
         if (k >= 2) begin
            checks++; if (result !== er[k-2]) begin errors++; $display("FAIL mode_result[%0d]: got %0d expected %0d", k-2, result, er[k-2]); end
            checks++; if (cout !== ec[k-2]) begin errors++; $display("FAIL mode_cout[%0d]: got %b expected %b", k-2, cout, ec[k-2]); end
         end
      end
      tick(); settle();
   endtask

   task automatic test_reset_mid();
      tick();
      b_in1 = 8'd3; b_in2 = 8'd3; b_in_valid = 1'b1; b_out_ready = 1'b1;
      in_valid = 1'b0;
      settle();
      tick();
      b_in1 = 8'd4; b_in2 = 8'd4;
      in1 = 5'd3; in2 = 5'd3; in_valid = 1'b1;
      settle();
      tick();
      resetn = 1'b0;
      in1 = 5'd5; in2 = 5'd5; b_in1 = 8'd5; b_in2 = 8'd5;
      settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_b_ready: got %b expected 1", b_in_ready); end
      tick();
      resetn = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0;
      settle();
      checks++; if (result !== 10'd0) begin errors++; $display("FAIL rstmid_result: got %0d expected 0", result); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after_ready: got %b expected 1", in_ready); end
      for (int k = 0; k < 7; k++) begin
         if (k > 0) begin
            tick(); settle();
         end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid[%0d]: got %b expected 0", k, out_valid); end
         checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_b_valid[%0d]: got %b expected 0", k, b_out_valid); end
      end
   endtask

   task automatic test_random();
      logic [16:0] q [$];
      logic [16:0] ex;
      logic [15:0] pres;
      logic        pc;
      logic        hold;
      int          sent;
      int          got;
      int          cyc;
      sent = 0; got = 0; cyc = 0; hold = 1'b0; pres = '0; pc = 1'b0;
      while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
         tick();
         cyc++;
         b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         b_in1       = 8'($urandom_range(0, 255));
         b_in2       = 8'($urandom_range(0, 255));
         b_is_signed = 1'($urandom_range(0, 1));
         b_out_ready = ($urandom_range(0, 3) != 0);
         settle();
         if (hold) begin
            checks++; if (b_out_valid !== 1'b1 || b_result !== pres || b_cout !== pc) begin errors++; $display("FAIL rand_hold: got %b/%0d/%b expected 1/%0d/%b", b_out_valid, b_result, b_cout, pres, pc); end
         end
         if (b_out_valid && b_out_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rand_extra: got %0d expected none", b_result);
            end else begin
               ex = q.pop_front();
               got++;
               checks++; if (b_result !== ex[15:0]) begin errors++; $display("FAIL rand_result[%0d]: got %0d expected %0d", got, b_result, ex[15:0]); end
               checks++; if (b_cout !== ex[16]) begin errors++; $display("FAIL rand_cout[%0d]: got %b expected %b", got, b_cout, ex[16]); end
            end
         end
         if (b_in_valid && b_in_ready) begin
            q.push_back(ref8(b_in1, b_in2, b_is_signed));
            sent++;
         end
         hold = b_out_valid && !b_out_ready;
         pres = b_result;
         pc   = b_cout;
      end
      b_in_valid = 1'b0;
      checks++; if (got != 1000 || q.size() != 0) begin errors++; $display("FAIL rand_count: got %0d drained %0d pending expected 1000 drained 0 pending", got, q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_signed();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wtm_pipe.md
WTM_PIPE -- requirements
Module: wtm_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand width in bits, legal range 2..16.
REQ-002 SHALL have parameter STAGES, default 2, number of register stages (latency), legal range 1..4.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair presented.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port in1  input  WIDTH  multiplicand.
REQ-008 SHALL have port in2  input  WIDTH  multiplier.
REQ-009 SHALL have port is_signed  input  1  operands are two's complement when high; sampled with in1/in2.
REQ-010 SHALL have port out_valid  output  1  result/cout hold a valid product.
REQ-011 SHALL have port out_ready  input  1  consumer takes the product this cycle.
REQ-012 SHALL have port result  output  2*WIDTH  full product.
REQ-013 SHALL have port cout  output  1  product does not fit in WIDTH bits.

Function
REQ-014 SHALL form partial products of in1/in2, reduce them with a Wallace tree of full/half adders and finish with a carry-propagate adder, with registers distributed over STAGES stages.
REQ-015 SHALL accept a pair on a cycle where in_valid and in_ready are both high (transfer).
REQ-016 SHALL present the product of a transfer at cycle T on result with out_valid high at cycle T+STAGES when no stall occurs.
REQ-017 SHALL advance the whole pipeline when out_ready is high or out_valid is low; otherwise hold every stage unchanged.
REQ-018 SHALL drive in_ready equal to the pipeline-advance condition of REQ-017 (combinational from out_ready and out_valid).
REQ-019 SHALL hold result, cout and out_valid stable while out_valid is high and out_ready is low.
REQ-020 SHALL, on a cycle with both an input transfer and an output transfer, accept and drain in the same cycle with no bubble and no loss.
REQ-021 SHALL insert a bubble (stage valid low) when the pipeline advances without an input transfer.
REQ-022 SHALL sustain one product per cycle when in_valid and out_ready are held high.
REQ-023 SHALL compute unsigned: result = in1*in2 modulo 2^(2*WIDTH); cout = 1 when result[2*WIDTH-1:WIDTH] is non-zero.
REQ-024 SHALL compute signed (is_signed high): result = two's-complement product sign-extended to 2*WIDTH bits; cout = 1 when result[2*WIDTH-1:WIDTH-1] is not all equal.
REQ-025 SHALL carry is_signed through the pipeline alongside its operands, so mode may change every transfer.
REQ-026 SHALL drive result and cout to 0 whenever out_valid is low.

Reset
REQ-027 SHALL, when resetn is low at a rising clock edge, clear every stage valid bit, giving out_valid = 0, result = 0, cout = 0 on the following cycle.
REQ-028 SHALL discard all in-flight products when reset is asserted mid-operation; no discarded product is ever presented.
REQ-029 SHALL drive in_ready high during and after reset (pipeline empty), and SHALL ignore in_valid on cycles where resetn is low.

Configuration
REQ-030 SHALL, with macro WTM_SIGNED_EN defined, implement signed mode per REQ-024 (Baugh-Wooley partial-product correction in the tree).
REQ-031 SHALL, without WTM_SIGNED_EN, keep the is_signed port, ignore it, and always compute per REQ-023, with no signed-correction logic.

Verification
REQ-032 SHALL cover: WIDTH=5, STAGES=2, out_ready=1, in1=3, in2=8 unsigned at cycle T -> out_valid at T+2, result=24, cout=0.
REQ-033 SHALL cover: back-to-back unsigned 31*3, 29*7, 20*0 -> results 93, 203, 0 on three consecutive cycles, with cout=1, 1, 0.
REQ-034 SHALL cover: 25*16 issued, out_ready=0 for 4 cycles -> result=400, cout=1 held stable; in_ready=0 once the pipe is full; released with no loss or duplication.
REQ-035 SHALL cover: in1=in2=5'b11111 with WTM_SIGNED_EN -> signed gives result=1, cout=0; unsigned gives result=961 (10'h3C1), cout=1.
REQ-036 SHALL cover: reset pulsed low one cycle with two products in flight -> out_valid=0 next cycle, neither product ever appears, and in_ready=1.
REQ-037 SHALL cover: WIDTH=8, STAGES=4, 1000 random operand pairs with random in_valid/out_ready -> every result/cout matches a reference model in order.
